sd_sdram_writer: RTL and testbench
==================================

Name: sd_sdram_writer

Overview:
Downstream consumer of the SD card reader's 16-bit `sd_valid`/`sd_data` stream. It buffers words in an internal FIFO and issues fixed-length write bursts to the SDRAM controller write port. The write address advances linearly through one picture frame and wraps at the frame end. It sits between the SD reader top and the SDRAM controller, and holds off all activity until SDRAM initialisation completes.

Parameters:
DATA_W, 16, data word width
ADDR_W, 22, SDRAM word-address width
BURST_LEN, 256, words per write burst (power of 2, at most FIFO_DEPTH/2)
FIFO_DEPTH, 512, buffer depth in words (power of 2)
FRAME_WORDS, 786432, words per picture (1024x768); must be a multiple of BURST_LEN
BASE_ADDR, 0, first word address of the frame buffer

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sdram_init_done  in  1  SDRAM controller ready; no requests while low
sd_valid  in  1  single-cycle strobe, sd_data valid
sd_data  in  DATA_W  picture word from the SD reader
pic_read_done  in  1  level; SD reader has finished the picture
wr_req  out  1  burst write request
wr_ack  in  1  one-cycle pulse: controller accepted the request
wr_addr  out  ADDR_W  burst start address, held stable while wr_req=1
wr_len  out  clog2(BURST_LEN)+1  words in this burst
wr_data_en  in  1  controller pulls one word this cycle
wr_data  out  DATA_W  FIFO head word (first-word-fall-through)
frame_done  out  1  one-cycle pulse when the last frame word is popped
fifo_overflow  out  1  sticky: a word arrived while the FIFO was full
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: wr_req=0, wr_addr=BASE_ADDR, wr_len=0, wr_data=0, frame_done=0, fifo_overflow=0, busy=0. FIFO is emptied and the FSM enters IDLE.
- Push: when sd_valid=1 and the FIFO is not full, sd_data is written to the FIFO. The word is visible at the head one cycle later.
- Push when full: the word is dropped and fifo_overflow is set. It stays set until reset.
- Pop: each wr_data_en=1 cycle with the FIFO non-empty pops one word. wr_data shows the new head on the next cycle.
- wr_data_en while empty: protocol error. No pop; wr_data holds its value; the bench flags it.
- Simultaneous push and pop: the count is unchanged.
- FSM states:
  - IDLE: wait for sdram_init_done=1, then go to FILL.
  - FILL: if count >= BURST_LEN, set wr_len=BURST_LEN and go to REQ. Else if pic_read_done=1 and count > 0, set wr_len=count (flush) and go to REQ.
  - REQ: drive wr_req=1 with wr_addr and wr_len held. On wr_ack go to BURST; wr_req drops the following cycle.
  - BURST: count pops. After wr_len pops, go to NEXT.
  - NEXT: wr_addr += wr_len.
    - If wr_addr - BASE_ADDR then equals FRAME_WORDS: wr_addr = BASE_ADDR and frame_done pulses.
    - frame_done pulses on the cycle after the final pop.
    - Then go to FILL.
- Flush: a flush burst is issued only once pic_read_done is high. Pushes arriving during a burst remain in the FIFO for the next burst.
- Address arithmetic: ADDR_W wide, unsigned. Wrap is decided by comparison with FRAME_WORDS, never by natural overflow.
- sdram_init_done falling while not in IDLE: the current burst completes, then the FSM returns to IDLE. The FIFO keeps its contents.
- Reset mid-burst: everything clears immediately. The controller must tolerate wr_req vanishing.

Optional Feature:
- Macro: SD_WR_BYTE_SWAP_EN.
- Defined: sd_data[15:8] and sd_data[7:0] are swapped before the FIFO push, converting little-endian BMP pixels.
- Undefined: words are stored unmodified.
- FIFO latency and all handshakes are identical in both builds.

Decomposition:
- Package sd_sdram_pkg: DATA_W/ADDR_W defaults, the state enum (IDLE, FILL, REQ, BURST, NEXT), and the wr_len width function.
- Sub-module sd_wr_fifo: synchronous FWFT FIFO with parameterised DATA_W and DEPTH. It provides count, full, empty, and push-when-full drop. The top holds the FSM, address counter and burst counter.

Test Plan:
- Reset, then sdram_init_done=1 and 256 sd_valid pulses with data 0..255 -> one wr_req, wr_addr=0, wr_len=256; pops return 0..255 in order; then wr_addr=256.
- 300 words then pic_read_done=1 -> bursts of 256 at addr 0 and 44 at addr 256 (flush); FIFO ends empty.
- 786432 words -> 3072 bursts; frame_done pulses once after the last pop; wr_addr returns to 0.
- wr_data_en withheld, 513 pushes -> the 513th word is dropped and fifo_overflow=1; later pops return words 0..511.
- Push and pop in the same cycle at count=256 -> count stays 256; no data lost or duplicated.
- Assert rst_n=0 mid-burst (after 100 pops) -> all outputs take reset values; a fresh 256-word sequence restarts at wr_addr=0. With SD_WR_BYTE_SWAP_EN, push 0x1234 -> 0x3412 is popped.

Source files
------------

// File: rtl/sd_sdram_pkg.sv
// Shared types and defaults for the SD-card-to-SDRAM picture writer.
package sd_sdram_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 22;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        REQ,
        BURST,
        NEXT
    } wr_state_e;

    // wr_len must be able to hold BURST_LEN itself, hence the extra bit.
    function automatic int len_w(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/sd_wr_fifo.sv
// First-word-fall-through FIFO: the head word is held in an output register
// and is valid one cycle after the push that brings it to the head.
module sd_wr_fifo
    import sd_sdram_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = 512,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign rd_ptr_d = rd_ptr + PTR_W'(pop_ok);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers, count and the head register are cleared, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_d;
            count  <= count_d;
            // The new head is the word being written right now when it lands in the slot being read next.
            if (count_d != '0) begin
                dout <= (push_ok && (rd_ptr_d == wr_ptr)) ? din : mem[rd_ptr_d];
            end
        end
    end

endmodule

// File: rtl/sd_sdram_writer.sv
// Buffers the SD reader word stream and writes it to SDRAM in fixed bursts
// through one frame. Optional SD_WR_BYTE_SWAP_EN swaps bytes before buffering.
module sd_sdram_writer
    import sd_sdram_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BURST_LEN   = 256,
    parameter int FIFO_DEPTH  = 512,
    parameter int FRAME_WORDS = 786432,
    parameter int BASE_ADDR   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sdram_init_done,
    input  logic                         sd_valid,
    input  logic [DATA_W-1:0]            sd_data,
    input  logic                         pic_read_done,
    output logic                         wr_req,
    input  logic                         wr_ack,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [len_w(BURST_LEN)-1:0]  wr_len,
    input  logic                         wr_data_en,
    output logic [DATA_W-1:0]            wr_data,
    output logic                         frame_done,
    output logic                         fifo_overflow,
    output logic                         busy
);

    localparam int                LEN_W  = len_w(BURST_LEN);
    localparam int                CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] FRAME  = ADDR_W'(FRAME_WORDS);

    wr_state_e         state_q;
    wr_state_e         state_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [LEN_W-1:0]  wr_len_d;
    logic [LEN_W-1:0]  burst_cnt;
    logic [LEN_W-1:0]  burst_cnt_d;
    logic [ADDR_W-1:0] next_addr;
    logic              frame_end;
    logic [DATA_W-1:0] push_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_fire;

`ifdef SD_WR_BYTE_SWAP_EN
    assign push_data = {sd_data[7:0], sd_data[15:8]};
`else
    assign push_data = sd_data;
`endif

    sd_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (sd_valid),
        .din   (push_data),
        .pop   (wr_data_en),
        .dout  (wr_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop_fire  = wr_data_en && !fifo_empty;
    assign busy      = (state_q != IDLE);
    // Wrap is an explicit compare against the frame size, not address overflow.
    assign next_addr = wr_addr + ADDR_W'(wr_len);
    assign frame_end = ((next_addr - BASE_A) == FRAME);

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr;
        wr_len_d    = wr_len;
        burst_cnt_d = burst_cnt;
        wr_req      = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sdram_init_done) state_d = FILL;
            end
            FILL: begin
                if (!sdram_init_done) begin
                    state_d = IDLE;
                end else if (fifo_count >= CNT_W'(BURST_LEN)) begin
                    wr_len_d = LEN_W'(BURST_LEN);
                    state_d  = REQ;
                end else if (pic_read_done && !fifo_empty) begin
                    wr_len_d = LEN_W'(fifo_count);
                    state_d  = REQ;
                end
            end
            REQ: begin
                wr_req = 1'b1;
                // An unaccepted request is withdrawn if the controller loses init.
                if (wr_ack) begin
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end else if (!sdram_init_done) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (pop_fire) begin
                    if (burst_cnt == wr_len - LEN_W'(1)) begin
                        burst_cnt_d = '0;
                        state_d     = NEXT;
                    end else begin
                        burst_cnt_d = burst_cnt + LEN_W'(1);
                    end
                end
            end
            NEXT: begin
                if (frame_end) begin
                    wr_addr_d  = BASE_A;
                    frame_done = 1'b1;
                end else begin
                    wr_addr_d = next_addr;
                end
                state_d = sdram_init_done ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_addr       <= BASE_A;
            wr_len        <= '0;
            burst_cnt     <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr   <= wr_addr_d;
            wr_len    <= wr_len_d;
            burst_cnt <= burst_cnt_d;
            if (sd_valid && fifo_full) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_sdram_writer.sv
// Randomized bench for sd_sdram_writer: a queue-based model of the buffer and
// frame address, plus a bench-side SDRAM write-port responder.
module tb_sd_sdram_writer;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 22;
    localparam int BURST_LEN   = 256;
    localparam int FIFO_DEPTH  = 512;
    localparam int FRAME_WORDS = 3072;
    localparam int BASE_ADDR   = 0;
    localparam int LEN_W       = $clog2(BURST_LEN) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sdram_init_done = 1'b0;
    logic              sd_valid = 1'b0;
    logic [DATA_W-1:0] sd_data = '0;
    logic              pic_read_done = 1'b0;
    logic              wr_ack = 1'b0;
    logic              wr_data_en = 1'b0;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              fifo_overflow;
    logic              busy;

    sd_sdram_writer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FRAME_WORDS (FRAME_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .sd_valid        (sd_valid),
        .sd_data         (sd_data),
        .pic_read_done   (pic_read_done),
        .wr_req          (wr_req),
        .wr_ack          (wr_ack),
        .wr_addr         (wr_addr),
        .wr_len          (wr_len),
        .wr_data_en      (wr_data_en),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .fifo_overflow   (fifo_overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef enum {C_WAIT, C_ACK, C_POP} ctrl_e;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] to_send[$];
    logic [DATA_W-1:0] last_popped;
    ctrl_e             mode = C_WAIT;
    int                push_pct = 100;
    int                pop_pct = 100;
    bit                hold = 1'b0;
    bit                stray_pop = 1'b0;
    bit                exp_ovf = 1'b0;
    int                ack_wait;
    int                remaining;
    int                burst_len_exp;
    int                burst_pops;
    longint            exp_addr;
    int                frame_pulses;
    int                exp_frames;

    function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] w);
`ifdef SD_WR_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    // One clock: drive inputs, advance the model at the edge, observe 1 time unit later.
    task automatic cycle();
        int                pre_size;
        bit                pushed;
        bit                popped;
        bit                acked;
        logic [DATA_W-1:0] word;
        pushed = 1'b0;
        popped = 1'b0;
        acked  = 1'b0;
        word   = '0;
        sd_valid   = 1'b0;
        wr_ack     = 1'b0;
        wr_data_en = 1'b0;
        if (to_send.size() > 0 && int'($urandom_range(99)) < push_pct) begin
            word     = to_send.pop_front();
            sd_valid = 1'b1;
            sd_data  = word;
            pushed   = 1'b1;
        end
        case (mode)
            C_ACK: begin
                if (ack_wait == 0) begin
                    wr_ack = 1'b1;
                    acked  = 1'b1;
                end else begin
                    ack_wait--;
                end
            end
            C_POP: begin
                if (remaining > 0 && q.size() > 0 && int'($urandom_range(99)) < pop_pct) begin
                    wr_data_en = 1'b1;
                    popped     = 1'b1;
                    check("pop_data", wr_data, q[0]);
                end
            end
            default: ;
        endcase
        if (stray_pop) begin
            wr_data_en = 1'b1;
            stray_pop  = 1'b0;
        end
        pre_size = q.size();
        @(posedge clk);
        if (popped) begin
            last_popped = q.pop_front();
            remaining--;
            burst_pops++;
        end
        if (pushed) begin
            if (pre_size >= FIFO_DEPTH) exp_ovf = 1'b1;
            else q.push_back(stored(word));
        end
        #1;
        if (frame_done) frame_pulses++;
        if (acked) begin
            check("req_drop", wr_req, 0);
            mode       = C_POP;
            remaining  = burst_len_exp;
            burst_pops = 0;
        end
        if (popped && remaining == 0) begin
            exp_addr += burst_len_exp;
            if (exp_addr == FRAME_WORDS) begin
                exp_addr = 0;
                exp_frames++;
                check("frame_done_last", frame_done, 1);
            end else begin
                check("frame_done_mid", frame_done, 0);
            end
            mode = C_WAIT;
        end
        if (mode == C_WAIT && wr_req && !hold) begin
            burst_len_exp = (pic_read_done && q.size() < BURST_LEN) ? q.size() : BURST_LEN;
            check("req_addr", wr_addr, BASE_ADDR + exp_addr);
            check("req_len", wr_len, burst_len_exp);
            ack_wait = int'($urandom_range(2));
            mode     = C_ACK;
        end
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        sd_valid        = 1'b0;
        wr_ack          = 1'b0;
        wr_data_en      = 1'b0;
        pic_read_done   = 1'b0;
        sdram_init_done = 1'b0;
        #1;
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_addr", wr_addr, BASE_ADDR);
        check("rst_wr_len", wr_len, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", fifo_overflow, 0);
        check("rst_busy", busy, 0);
        q.delete();
        to_send.delete();
        mode         = C_WAIT;
        exp_addr     = 0;
        exp_ovf      = 1'b0;
        hold         = 1'b0;
        frame_pulses = 0;
        exp_frames   = 0;
        push_pct     = 100;
        pop_pct      = 100;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_send(input string tag, input int budget);
        int n = 0;
        while (to_send.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check(tag, (n < budget), 1);
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n = 0;
        while ((to_send.size() > 0 || q.size() > 0 || mode != C_WAIT) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, (n < budget), 1);
        repeat (3) cycle();
    endtask

    task automatic run_until_popping(input string tag, input int min_pops, input int budget);
        int n = 0;
        while (!(mode == C_POP && burst_pops >= min_pops) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, (n < budget), 1);
    endtask

    initial begin
        #2;
        // Single aligned burst; nothing happens until init completes.
        apply_reset();
        repeat (3) cycle();
        check("idle_busy", busy, 0);
        check("idle_req", wr_req, 0);
        sdram_init_done = 1'b1;
        cycle();
        check("fill_busy", busy, 1);
        for (int i = 0; i < 256; i++) to_send.push_back(DATA_W'(i));
        run_drain("t1_drain", 2000);
        check("t1_addr", wr_addr, BASE_ADDR + exp_addr);
        stray_pop = 1'b1;
        cycle();
        check("stray_pop_hold", wr_data, last_popped);

        // Full burst plus a flush of the remainder.
        apply_reset();
        sdram_init_done = 1'b1;
        to_send.push_back(16'h1234);
        cycle();
        check("head_word", wr_data, stored(16'h1234));
        for (int i = 1; i < 300; i++) to_send.push_back(DATA_W'($urandom));
        run_send("t2_send", 2000);
        pic_read_done = 1'b1;
        run_drain("t2_drain", 2000);
        repeat (20) cycle();
        check("t2_no_req", wr_req, 0);
        check("t2_addr", wr_addr, BASE_ADDR + exp_addr);
        pic_read_done = 1'b0;

        // Whole frame with random gaps on both sides.
        apply_reset();
        sdram_init_done = 1'b1;
        push_pct = 70;
        pop_pct  = 80;
        for (int i = 0; i < FRAME_WORDS; i++) to_send.push_back(DATA_W'($urandom));
        run_drain("t3_drain", 20000);
        check("t3_frame_pulses", frame_pulses, exp_frames);
        check("t3_frames_seen", frame_pulses, 1);
        check("t3_addr_wrap", wr_addr, BASE_ADDR + exp_addr);

        // Overflow: controller stalls, 513 words offered.
        apply_reset();
        sdram_init_done = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) to_send.push_back(DATA_W'(i));
        run_send("t4_send", 2000);
        cycle();
        check("ovf_clear", fifo_overflow, exp_ovf);
        to_send.push_back(DATA_W'(FIFO_DEPTH));
        run_send("t4_send_extra", 10);
        cycle();
        check("ovf_set", fifo_overflow, exp_ovf);
        hold = 1'b0;
        run_drain("t4_drain", 3000);
        check("ovf_sticky", fifo_overflow, exp_ovf);

        // Simultaneous push and pop with 256 words buffered.
        apply_reset();
        sdram_init_done = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 256; i++) to_send.push_back(DATA_W'($urandom));
        run_send("t5_send", 2000);
        repeat (3) cycle();
        hold = 1'b0;
        run_until_popping("t5_start", 0, 50);
        for (int i = 0; i < 256; i++) to_send.push_back(DATA_W'($urandom));
        run_drain("t5_drain", 3000);
        check("t5_addr", wr_addr, BASE_ADDR + exp_addr);

        // Reset in the middle of a burst, then a fresh burst from the base.
        apply_reset();
        sdram_init_done = 1'b1;
        for (int i = 0; i < 256; i++) to_send.push_back(DATA_W'($urandom));
        run_until_popping("t6_midburst", 100, 2000);
        apply_reset();
        sdram_init_done = 1'b1;
        for (int i = 0; i < 256; i++) to_send.push_back(DATA_W'(i + 1000));
        run_drain("t6_drain", 2000);
        check("t6_addr", wr_addr, BASE_ADDR + exp_addr);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
